// File: rtl/key_load_if.sv
// Key-word stream from the key source into key_load_ctrl.
// Carries the 32-bit word, its framing, the key size and the accept handshake.
interface key_load_if;
  logic [1:0]  mode_in;
  logic        kw_valid;
  logic        kw_ready;
  logic [31:0] kw_data;
  logic        kw_last;

  modport master (output mode_in, output kw_valid, output kw_data, output kw_last, input kw_ready);
  modport slave  (input mode_in, input kw_valid, input kw_data, input kw_last, output kw_ready);
endinterface

// File: rtl/key_load_ctrl.sv
// Collects a 128/192/256-bit cipher key word by word and sequences the round-key expander.
// Reports key_ready once expansion completes, or a sticky err on framing faults or timeout.
module key_load_ctrl #(
  parameter int TIMEOUT_CYC = 64,
  parameter int EXP_GUARD   = 2
) (
  input  logic         clk,
  input  logic         reset,
  key_load_if.slave    kw,
  input  logic         key_clr,
  output logic [255:0] short_key,
  output logic [1:0]   aes_mode,
  output logic         exp_reset,
  input  logic         exp_done,
  output logic         key_ready,
  output logic         busy,
  output logic         err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EXPAND, S_READY, S_ERROR} state_t;

  state_t          state_reg, state_next;
  logic [255:0]    key_reg, key_next;
  logic [1:0]      mode_reg, mode_next;
  logic [3:0]      count_reg, count_next;
  logic [TW-1:0]   timer_reg, timer_next;
  logic            exp_reset_reg, key_ready_reg, busy_reg, err_reg;
  logic            accept;
  logic            zero_key;
  logic            wr_en;
  logic [2:0]      wr_slot;
  logic [3:0]      n_words;
  logic [3:0]      count_inc;

  function automatic logic [3:0] words_for(input logic [1:0] m);
    case (m)
      2'b00:   return 4'd4;
      2'b01:   return 4'd6;
      default: return 4'd8;
    endcase
  endfunction

  assign kw.kw_ready = !key_clr &&
                       (state_reg == S_IDLE || state_reg == S_LOAD || state_reg == S_READY);
  assign accept      = kw.kw_valid && kw.kw_ready;
  assign n_words     = words_for(mode_reg);
  assign count_inc   = count_reg + 4'd1;

  always_comb begin
    state_next = state_reg;
    mode_next  = mode_reg;
    count_next = count_reg;
    timer_next = timer_reg;
    zero_key   = 1'b0;
    wr_en      = 1'b0;
    wr_slot    = 3'd0;

    case (state_reg)
      S_IDLE, S_READY: begin
        if (accept) begin
          // A fresh load wipes the previous key so unused upper words read as zero.
          mode_next  = kw.mode_in;
          zero_key   = 1'b1;
          wr_en      = 1'b1;
          wr_slot    = 3'(words_for(kw.mode_in) - 4'd1);
          count_next = 4'd1;
          state_next = kw.kw_last ? S_ERROR : S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept) begin
          wr_en      = 1'b1;
          wr_slot    = 3'(n_words - count_inc);
          count_next = count_inc;
          if (kw.kw_last) begin
            state_next = (count_inc == n_words) ? S_EXPAND : S_ERROR;
            timer_next = '0;
          end else if (count_inc == n_words) begin
            state_next = S_ERROR;
          end
        end
      end
      S_EXPAND: begin
        // Done wins over timeout when both land on the final allowed cycle.
        if (exp_done && timer_reg >= TW'(EXP_GUARD)) begin
          state_next = S_READY;
        end else if (timer_reg == TW'(TIMEOUT_CYC - 1)) begin
          state_next = S_ERROR;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      default: ;
    endcase

    if (key_clr) begin
      state_next = S_IDLE;
      zero_key   = 1'b1;
      wr_en      = 1'b0;
      count_next = 4'd0;
      timer_next = '0;
    end
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_key_word
    assign key_next[32*gi +: 32] = (wr_en && wr_slot == 3'(gi)) ? kw.kw_data :
                                   (zero_key ? 32'd0 : key_reg[32*gi +: 32]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      key_reg       <= '0;
      mode_reg      <= 2'b00;
      count_reg     <= 4'd0;
      timer_reg     <= '0;
      exp_reset_reg <= 1'b1;
      key_ready_reg <= 1'b0;
      busy_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      key_reg       <= key_next;
      mode_reg      <= mode_next;
      count_reg     <= count_next;
      timer_reg     <= timer_next;
      // Status flags are registered from the next state so they align with it.
      exp_reset_reg <= !(state_next == S_EXPAND || state_next == S_READY);
      key_ready_reg <= (state_next == S_READY);
      busy_reg      <= (state_next == S_LOAD || state_next == S_EXPAND);
      err_reg       <= (state_next == S_ERROR);
    end
  end

  assign short_key = key_reg;
  assign aes_mode  = mode_reg;
  assign exp_reset = exp_reset_reg;
  assign key_ready = key_ready_reg;
  assign busy      = busy_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_key_load_ctrl.sv
// Bench for key_load_ctrl: scoreboard of expected load outcomes popped on key_ready/err,
// plus direct checks of handshake, guard/timeout timing, key_clr and async reset.
module tb_key_load_ctrl;
  logic         clk = 1'b0;
  logic         reset;
  logic         key_clr;
  logic         exp_done;
  logic [255:0] short_key;
  logic [1:0]   aes_mode;
  logic         exp_reset, key_ready, busy, err;

  key_load_if kif ();

  key_load_ctrl #(.TIMEOUT_CYC(64), .EXP_GUARD(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .kw        (kif),
    .key_clr   (key_clr),
    .short_key (short_key),
    .aes_mode  (aes_mode),
    .exp_reset (exp_reset),
    .exp_done  (exp_done),
    .key_ready (key_ready),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] key;
    logic [1:0]   mode;
    logic         is_err;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] wbuf [8];

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic int words_for(input logic [1:0] m);
    return (m == 2'b00) ? 4 : (m == 2'b01) ? 6 : 8;
  endfunction

  function automatic logic [255:0] build_key(input int n);
    logic [255:0] k = '0;
    for (int i = 0; i < n; i++) k[32*(n-i)-1 -: 32] = wbuf[i];
    return k;
  endfunction

  task automatic push_exp(input logic [1:0] m, input logic is_err);
    exp_t e;
    e.key    = build_key(words_for(m));
    e.mode   = m;
    e.is_err = is_err;
    sb_q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_word(input logic [31:0] d, input logic last, input logic [1:0] m);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    kif.mode_in  = m;
    kif.kw_data  = d;
    kif.kw_last  = last;
    kif.kw_valid = 1'b1;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = kif.kw_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check_eq("send_accept_timeout", 256'(acc), 256'd1);
    kif.kw_valid = 1'b0;
    kif.kw_last  = 1'b0;
  endtask

  task automatic load_key(input logic [1:0] m, input int first, input int nsend,
                          input int last_at, input int max_gap, input logic chk_busy);
    for (int k = first; k < nsend; k++) begin
      repeat ($urandom_range(0, max_gap)) begin
        @(posedge clk);
        #1;
      end
      send_word(wbuf[k], k == last_at, m);
      if (chk_busy) begin
        @(negedge clk);
        check_eq("busy_during_load", 256'(busy), 256'd1);
        check_eq("no_err_during_load", 256'(err), 256'd0);
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_outcome(input int budget);
    int n = 0;
    while (!(key_ready || err) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!(key_ready || err)) check_eq("outcome_timeout", 256'd0, 256'd1);
  endtask

  task automatic clear_key(input logic with_valid);
    key_clr      = 1'b1;
    kif.kw_valid = with_valid;
    kif.kw_data  = 32'hDEADBEEF;
    kif.mode_in  = 2'b10;
    #1;
    check_eq("kw_ready_low_on_clr", 256'(kif.kw_ready), 256'd0);
    @(posedge clk);
    #1;
    key_clr      = 1'b0;
    kif.kw_valid = 1'b0;
    @(negedge clk);
    check_eq("clr_short_key", short_key, 256'd0);
    check_eq("clr_err", 256'(err), 256'd0);
    check_eq("clr_busy", 256'(busy), 256'd0);
    check_eq("clr_exp_reset", 256'(exp_reset), 256'd1);
    check_eq("clr_kw_ready", 256'(kif.kw_ready), 256'd1);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: a rising key_ready or err completes the oldest pending load.
  logic prev_kr = 1'b0, prev_err = 1'b0;
  always @(negedge clk) begin
    if ((key_ready && !prev_kr) || (err && !prev_err)) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_unexpected_outcome", 256'd1, 256'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        $display("outcome: key_ready=%0b err=%0b mode=%0b key=%h", key_ready, err, aes_mode, short_key);
        check_eq("sb_err", 256'(err), 256'(e.is_err));
        check_eq("sb_key_ready", 256'(key_ready), 256'(!e.is_err));
        if (!e.is_err) begin
          check_eq("sb_short_key", short_key, e.key);
          check_eq("sb_aes_mode", 256'(aes_mode), 256'(e.mode));
        end
      end
    end
    prev_kr  = key_ready;
    prev_err = err;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    reset        = 1'b1;
    key_clr      = 1'b0;
    exp_done     = 1'b0;
    kif.kw_valid = 1'b0;
    kif.kw_data  = '0;
    kif.kw_last  = 1'b0;
    kif.mode_in  = 2'b00;
    #12;
    check_eq("rst_short_key", short_key, 256'd0);
    check_eq("rst_aes_mode", 256'(aes_mode), 256'd0);
    check_eq("rst_exp_reset", 256'(exp_reset), 256'd1);
    check_eq("rst_key_ready", 256'(key_ready), 256'd0);
    check_eq("rst_busy", 256'(busy), 256'd0);
    check_eq("rst_err", 256'(err), 256'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_eq("idle_kw_ready", 256'(kif.kw_ready), 256'd1);

    // Mode 00, exp_done held high: guard delays READY until EXPAND cycle 2 is sampled.
    wbuf[0] = 32'h2b7e1516; wbuf[1] = 32'h28aed2a6; wbuf[2] = 32'habf71588; wbuf[3] = 32'h09cf4f3c;
    push_exp(2'b00, 1'b0);
    exp_done = 1'b1;
    load_key(2'b00, 0, 4, 3, 0, 1'b0);
    @(negedge clk);
    check_eq("t1_exp_reset_low", 256'(exp_reset), 256'd0);
    check_eq("t1_kr_cyc0", 256'(key_ready), 256'd0);
    check_eq("t1_kw_ready_expand", 256'(kif.kw_ready), 256'd0);
    @(negedge clk);
    check_eq("t1_kr_cyc1", 256'(key_ready), 256'd0);
    @(negedge clk);
    check_eq("t1_kr_cyc2", 256'(key_ready), 256'd0);
    @(negedge clk);
    check_eq("t1_kr_after_cyc2", 256'(key_ready), 256'd1);
    check_eq("t1_busy_ready", 256'(busy), 256'd0);
    exp_done = 1'b0;
    @(posedge clk);
    #1;

    // Mode 10, 8 words with random gaps; busy must stay high.
    for (int k = 0; k < 8; k++) wbuf[k] = 32'h00010203 + 32'(k) * 32'h04040404;
    push_exp(2'b10, 1'b0);
    load_key(2'b10, 0, 8, 7, 2, 1'b1);
    repeat (3) @(negedge clk);
    check_eq("t2_busy_expand", 256'(busy), 256'd1);
    exp_done = 1'b1;
    wait_outcome(20);
    exp_done = 1'b0;
    @(posedge clk);
    #1;

    // From READY, a new mode 11 load drops key_ready on the first accept edge.
    check_eq("t3_ready_before", 256'(key_ready), 256'd1);
    check_eq("t3_exp_reset_before", 256'(exp_reset), 256'd0);
    for (int k = 0; k < 8; k++) wbuf[k] = 32'hA5C30000 ^ (32'(k) * 32'h01111111);
    push_exp(2'b11, 1'b0);
    send_word(wbuf[0], 1'b0, 2'b11);
    @(negedge clk);
    check_eq("t3_kr_drop", 256'(key_ready), 256'd0);
    check_eq("t3_exp_reset_rise", 256'(exp_reset), 256'd1);
    check_eq("t3_busy", 256'(busy), 256'd1);
    @(posedge clk);
    #1;
    load_key(2'b11, 1, 8, 7, 1, 1'b0);
    exp_done = 1'b1;
    wait_outcome(20);
    exp_done = 1'b0;
    @(posedge clk);
    #1;

    // Mode 01 with last on word 4: short key.
    for (int k = 0; k < 8; k++) wbuf[k] = 32'h11110000 + 32'(k);
    push_exp(2'b01, 1'b1);
    load_key(2'b01, 0, 4, 3, 0, 1'b0);
    @(negedge clk);
    check_eq("t4_err", 256'(err), 256'd1);
    check_eq("t4_exp_reset", 256'(exp_reset), 256'd1);
    check_eq("t4_kw_ready", 256'(kif.kw_ready), 256'd0);
    check_eq("t4_key_ready", 256'(key_ready), 256'd0);
    @(posedge clk);
    #1;
    clear_key(1'b0);

    // Mode 00, fourth word without last: long key.
    push_exp(2'b00, 1'b1);
    load_key(2'b00, 0, 4, -1, 0, 1'b0);
    @(negedge clk);
    check_eq("t5_err_long", 256'(err), 256'd1);
    @(posedge clk);
    #1;
    clear_key(1'b0);

    // Valid load with no exp_done: error after exactly 64 EXPAND cycles.
    push_exp(2'b00, 1'b1);
    load_key(2'b00, 0, 4, 3, 0, 1'b0);
    cyc = 0;
    while (cyc < 200) begin
      @(negedge clk);
      if (err) break;
      cyc++;
    end
    check_eq("t6_timeout_cycles", 256'(cyc), 256'd64);
    @(posedge clk);
    #1;
    clear_key(1'b0);

    // key_clr with kw_valid in IDLE: the word must not be accepted.
    clear_key(1'b1);

    // Async reset mid-LOAD.
    for (int k = 0; k < 8; k++) wbuf[k] = 32'hCAFE0000 + 32'(k);
    load_key(2'b00, 0, 2, -1, 0, 1'b0);
    @(negedge clk);
    check_eq("t8_busy_load", 256'(busy), 256'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("t8_load_busy", 256'(busy), 256'd0);
    check_eq("t8_load_key", short_key, 256'd0);
    check_eq("t8_load_exp_reset", 256'(exp_reset), 256'd1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Async reset mid-EXPAND.
    load_key(2'b01, 0, 6, 5, 0, 1'b0);
    @(negedge clk);
    check_eq("t8_exp_mode", 256'(aes_mode), 256'd1);
    check_eq("t8_exp_exp_reset_low", 256'(exp_reset), 256'd0);
    #2 reset = 1'b1;
    #1;
    check_eq("t8_exp_exp_reset", 256'(exp_reset), 256'd1);
    check_eq("t8_exp_busy", 256'(busy), 256'd0);
    check_eq("t8_exp_aes_mode", 256'(aes_mode), 256'd0);
    check_eq("t8_exp_key", short_key, 256'd0);
    check_eq("t8_exp_key_ready", 256'(key_ready), 256'd0);
    check_eq("t8_exp_err", 256'(err), 256'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    check_eq("sb_drained", 256'(sb_q.size()), 256'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
